// File: rtl/ibex_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : ibex_wb_queue
// Brief    : Multi-entry in-order writeback queue between ID/EX and the
//            register file. LSU responses are matched in order to the oldest
//            unanswered load/store entry; a pending-write mask feeds ID.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_wb_queue #(
  parameter int unsigned Depth             = 2,
  parameter bit          ResetAll          = 1'b0,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_wb_i,
  input  logic [1:0]               instr_type_wb_i,
  input  logic [31:0]              pc_id_i,
  input  logic                     instr_is_compressed_id_i,
  input  logic                     instr_perf_count_id_i,
  input  logic [4:0]               rf_waddr_id_i,
  input  logic [31:0]              rf_wdata_id_i,
  input  logic                     rf_we_id_i,
  input  logic                     dummy_instr_id_i,
  input  logic [31:0]              rf_wdata_lsu_i,
  input  logic                     lsu_resp_valid_i,
  input  logic                     lsu_resp_err_i,
  output logic                     ready_wb_o,
  output logic                     outstanding_load_wb_o,
  output logic                     outstanding_store_wb_o,
  output logic [31:0]              rf_write_pending_o,
  output logic [$clog2(Depth):0]   occupancy_o,
  output logic [4:0]               rf_waddr_wb_o,
  output logic [31:0]              rf_wdata_wb_o,
  output logic                     rf_we_wb_o,
  output logic [31:0]              pc_wb_o,
  output logic                     instr_done_wb_o,
  output logic                     perf_instr_ret_wb_o,
  output logic                     perf_instr_ret_compressed_wb_o,
  output logic                     dummy_instr_wb_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] c_FULL_OCC = OccW'(Depth);

  // Writeback instruction classes (ibex_pkg::wb_instr_type_e encoding)
  localparam logic [1:0] c_WB_LOAD  = 2'b00;
  localparam logic [1:0] c_WB_STORE = 2'b01;

  // Control state
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] resp_q, resp_d;

  // Entry payload
  logic [31:0] pc_q       [Depth];
  logic [4:0]  waddr_q    [Depth];
  logic [31:0] wdata_q    [Depth];
  logic [31:0] lsu_data_q [Depth];
  logic        we_q       [Depth];
  logic        is_lsu_q   [Depth];
  logic        is_load_q  [Depth];
  logic        comp_q     [Depth];
  logic        perf_q     [Depth];
  logic        err_q      [Depth];

  logic            w_push;
  logic            w_head_valid;
  logic            w_head_done;
  logic            w_head_err;
  logic [31:0]     w_head_data;
  logic            w_resp_found;
  logic [PtrW-1:0] w_resp_idx;
  logic            w_resp_capture;
  logic            w_resp_at_head;
  logic [31:0]     w_pending;
  logic            w_out_load;
  logic            w_out_store;

  // Locate the oldest valid LSU entry still waiting for its response
  always_comb begin
    w_resp_found = 1'b0;
    w_resp_idx   = rd_ptr_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (!w_resp_found && valid_q[rd_ptr_q + PtrW'(i)] &&
          is_lsu_q[rd_ptr_q + PtrW'(i)] && !resp_q[rd_ptr_q + PtrW'(i)]) begin
        w_resp_found = 1'b1;
        w_resp_idx   = rd_ptr_q + PtrW'(i);
      end
    end
  end

  assign w_resp_capture = lsu_resp_valid_i && w_resp_found;
  assign w_resp_at_head = w_resp_capture && (w_resp_idx == rd_ptr_q);

  // A head LSU entry retires on the cycle its response lands (bypass)
  assign w_head_valid = valid_q[rd_ptr_q];
  assign w_head_done  = w_head_valid &&
                        (!is_lsu_q[rd_ptr_q] || resp_q[rd_ptr_q] || w_resp_at_head);
  assign w_head_err   = is_lsu_q[rd_ptr_q] &&
                        (w_resp_at_head ? lsu_resp_err_i : err_q[rd_ptr_q]);
  assign w_head_data  = w_resp_at_head ? rf_wdata_lsu_i : lsu_data_q[rd_ptr_q];

  assign ready_wb_o = (occ_q != c_FULL_OCC) || w_head_done;
  assign w_push     = en_wb_i && ready_wb_o;

  // Next-state of pointers, occupancy and flags; a push overrides a retire
  // or capture on the same slot since it starts a fresh entry there
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    valid_d  = valid_q;
    resp_d   = resp_q;
    if (w_resp_capture) begin
      resp_d[w_resp_idx] = 1'b1;
    end
    if (w_head_done) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
    if (w_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      resp_d[wr_ptr_q]  = 1'b0;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
    case ({w_push, w_head_done})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register; reset discards all entries
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= '0;
      resp_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      resp_q   <= resp_d;
    end
  end

  // Payload written on push, LSU result captured into its matched entry
  always_ff @(posedge clk_i) begin
    if (ResetAll && !rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        pc_q[i]       <= '0;
        waddr_q[i]    <= '0;
        wdata_q[i]    <= '0;
        lsu_data_q[i] <= '0;
        we_q[i]       <= 1'b0;
        is_lsu_q[i]   <= 1'b0;
        is_load_q[i]  <= 1'b0;
        comp_q[i]     <= 1'b0;
        perf_q[i]     <= 1'b0;
        err_q[i]      <= 1'b0;
      end
    end else begin
      if (w_push) begin
        pc_q[wr_ptr_q]      <= pc_id_i;
        waddr_q[wr_ptr_q]   <= rf_waddr_id_i;
        wdata_q[wr_ptr_q]   <= rf_wdata_id_i;
        we_q[wr_ptr_q]      <= rf_we_id_i;
        is_lsu_q[wr_ptr_q]  <= (instr_type_wb_i == c_WB_LOAD) ||
                               (instr_type_wb_i == c_WB_STORE);
        is_load_q[wr_ptr_q] <= (instr_type_wb_i == c_WB_LOAD);
        comp_q[wr_ptr_q]    <= instr_is_compressed_id_i;
        perf_q[wr_ptr_q]    <= instr_perf_count_id_i;
      end
      if (w_resp_capture) begin
        lsu_data_q[w_resp_idx] <= rf_wdata_lsu_i;
        err_q[w_resp_idx]      <= lsu_resp_err_i;
      end
    end
  end

  // Hazard mask and outstanding-LSU summary over all valid entries
  always_comb begin
    w_pending   = '0;
    w_out_load  = 1'b0;
    w_out_store = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_q[PtrW'(i)]) begin
        if (we_q[PtrW'(i)] || is_load_q[PtrW'(i)]) begin
          w_pending[waddr_q[PtrW'(i)]] = 1'b1;
        end
        if (is_lsu_q[PtrW'(i)] && !resp_q[PtrW'(i)]) begin
          if (is_load_q[PtrW'(i)]) begin
            w_out_load = 1'b1;
          end else begin
            w_out_store = 1'b1;
          end
        end
      end
    end
    w_pending[0] = 1'b0;
  end

  assign rf_write_pending_o     = w_pending;
  assign outstanding_load_wb_o  = w_out_load;
  assign outstanding_store_wb_o = w_out_store;
  assign occupancy_o            = occ_q;

  assign instr_done_wb_o = w_head_done;
  assign pc_wb_o         = w_head_valid ? pc_q[rd_ptr_q] : '0;
  assign rf_waddr_wb_o   = w_head_valid ? waddr_q[rd_ptr_q] : '0;
  assign rf_wdata_wb_o   = !w_head_valid     ? '0 :
                           is_lsu_q[rd_ptr_q] ? w_head_data : wdata_q[rd_ptr_q];
  assign rf_we_wb_o      = w_head_done &&
                           (is_lsu_q[rd_ptr_q] ? (is_load_q[rd_ptr_q] && !w_head_err)
                                               : we_q[rd_ptr_q]);

  assign perf_instr_ret_wb_o            = w_head_done && perf_q[rd_ptr_q] && !w_head_err;
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o && comp_q[rd_ptr_q];

  if (DummyInstructions) begin : g_dummy
    logic [Depth-1:0] dummy_q;
    // Dummy flag travels with its entry
    always_ff @(posedge clk_i) begin
      if (ResetAll && !rst_ni) begin
        dummy_q <= '0;
      end else if (w_push) begin
        dummy_q[wr_ptr_q] <= dummy_instr_id_i;
      end
    end
    assign dummy_instr_wb_o = w_head_done && dummy_q[rd_ptr_q];
  end else begin : g_no_dummy
    logic unused_dummy;
    assign unused_dummy     = dummy_instr_id_i;
    assign dummy_instr_wb_o = 1'b0;
  end

`ifdef IBEX_WB_QUEUE_ASSERT_ON
  // A push offered while not ready is dropped
  a_no_dropped_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
    en_wb_i |-> ready_wb_o);
  // Every LSU response must have an entry waiting for it
  a_resp_has_target: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> w_resp_found);
`endif

endmodule
`default_nettype wire
